// File: rtl/life_sequencer.sv
// ---------------------------------------------------------------------------
// life_sequencer
//
// Generation sequencer for the Game of Life datapath. It sits between the
// renderer, the double buffer and the life_logic block. Generations are paced
// off renderer frame ticks at a selectable speed; the sequencer supports
// free-run, pause, single-step and clear. Buffer swaps happen only on a frame
// tick, so the display never shows a half-written board.
//
// Optional feature macro: LIFE_SEQ_TIMEOUT_EN
//   When defined, a compute watchdog is built. If life_logic does not report
//   done within TIMEOUT_CYCLES cycles, err_out is raised (sticky), the
//   generation is abandoned without a swap and the sequencer returns to idle.
//   When undefined, COMPUTE waits forever and err_out is tied low.
//
// Ports
//   clk_in         system clock
//   rst_in         asynchronous reset, active-high
//   speed_in       generation rate select, period = 2**LOG_MAX_SPEED - speed_in frames
//   run_in         level: 1 = free-run, 0 = paused
//   step_in        pulse: run one generation while paused
//   clear_in       pulse: zero the whole board
//   vsync_in       renderer vsync, rising edge marks a frame tick
//   logic_done_in  pulse: life_logic finished a generation
//   start_out      pulse: life_logic should start a generation
//   swap_out       pulse: double buffer swaps its read/write halves
//   we_out         write strobe used while clearing the write buffer
//   addr_w_out     line address used while clearing
//   data_out       line data used while clearing (always zero)
//   busy_out       sequencer is not idle
//   gen_count_out  number of generations completed
//   err_out        sticky compute-timeout flag
// ---------------------------------------------------------------------------
module life_sequencer #(
    parameter int ADDR_SIZE     = 3,
    parameter int LINE_WIDTH    = 8,
    parameter int LOG_MAX_SPEED = 3,
    parameter int GEN_WIDTH     = 16
`ifdef LIFE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     run_in,
    input  logic                     step_in,
    input  logic                     clear_in,
    input  logic                     vsync_in,
    input  logic                     logic_done_in,
    output logic                     start_out,
    output logic                     swap_out,
    output logic                     we_out,
    output logic [ADDR_SIZE-1:0]     addr_w_out,
    output logic [LINE_WIDTH-1:0]    data_out,
    output logic                     busy_out,
    output logic [GEN_WIDTH-1:0]     gen_count_out,
    output logic                     err_out
);

    // One extra bit so the slowest period (2**LOG_MAX_SPEED frames) fits.
    localparam int             PW         = LOG_MAX_SPEED + 1;
    localparam logic [PW-1:0]  MAX_PERIOD = PW'(2 ** LOG_MAX_SPEED);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COMPUTE,
        ST_SWAP,
        ST_CLEAR,
        ST_CLEAR_SWAP
    } state_t;

    state_t                 state_q, state_d;
    logic                   vsync_q, vsync_d;
    logic [PW-1:0]          frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]          period_q, period_d;
    logic                   clear_pend_q, clear_pend_d;
    logic [ADDR_SIZE-1:0]   clr_addr_q, clr_addr_d;
    logic [GEN_WIDTH-1:0]   gen_count_q, gen_count_d;
    logic                   start_q, start_d;
    logic                   swap_q, swap_d;
    logic                   frame_tick;

`ifdef LIFE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   err_q, err_d;
`endif

    // Single-cycle pulse on each rising edge of vsync.
    assign frame_tick = vsync_in & ~vsync_q;

    // State register and all sequencer flops.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            frame_cnt_q  <= '0;
            period_q     <= '0;
            clear_pend_q <= 1'b0;
            clr_addr_q   <= '0;
            gen_count_q  <= '0;
            start_q      <= 1'b0;
            swap_q       <= 1'b0;
`ifdef LIFE_SEQ_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            frame_cnt_q  <= frame_cnt_d;
            period_q     <= period_d;
            clear_pend_q <= clear_pend_d;
            clr_addr_q   <= clr_addr_d;
            gen_count_q  <= gen_count_d;
            start_q      <= start_d;
            swap_q       <= swap_d;
`ifdef LIFE_SEQ_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next-state logic. start/swap are computed here so they leave the block
    // registered: start lands on the first COMPUTE cycle, swap on the cycle
    // after the frame tick that committed it.
    always_comb begin
        state_d      = state_q;
        vsync_d      = vsync_in;
        frame_cnt_d  = frame_cnt_q;
        period_d     = period_q;
        clear_pend_d = clear_pend_q;
        clr_addr_d   = clr_addr_q;
        gen_count_d  = gen_count_q;
        start_d      = 1'b0;
        swap_d       = 1'b0;
`ifdef LIFE_SEQ_TIMEOUT_EN
        to_cnt_d     = '0;
        err_d        = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                // Clear beats step when both arrive together.
                if (clear_in) begin
                    state_d = ST_CLEAR;
                end else if (run_in) begin
                    state_d = ST_WAIT;
                end else if (step_in) begin
                    state_d = ST_COMPUTE;
                end
            end

            ST_WAIT: begin
                if (clear_in) begin
                    state_d     = ST_CLEAR;
                    frame_cnt_d = '0;
                end else if (!run_in) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    if ((frame_cnt_q + 1'b1) == period_q) begin
                        state_d     = ST_COMPUTE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_COMPUTE: begin
                // A clear requested mid-generation waits until this
                // generation has been swapped out.
                if (clear_in) begin
                    clear_pend_d = 1'b1;
                end
                if (logic_done_in) begin
                    state_d = ST_SWAP;
                end
`ifdef LIFE_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_IDLE;
                    err_d        = 1'b1;
                    clear_pend_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            ST_SWAP: begin
                if (clear_in) begin
                    clear_pend_d = 1'b1;
                end
                if (frame_tick) begin
                    swap_d      = 1'b1;
                    gen_count_d = gen_count_q + 1'b1;
                    if (clear_pend_q || clear_in) begin
                        state_d = ST_CLEAR;
                    end else if (run_in) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_CLEAR: begin
                // One line per cycle; the all-ones address is the last line.
                if (clr_addr_q == '1) begin
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR_SWAP;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end

            ST_CLEAR_SWAP: begin
                // Always lands in IDLE: a clear leaves the board paused.
                if (frame_tick) begin
                    swap_d       = 1'b1;
                    gen_count_d  = '0;
                    clear_pend_d = 1'b0;
                    state_d      = ST_IDLE;
`ifdef LIFE_SEQ_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The rate is latched once per WAIT so a speed change mid-wait
        // cannot shorten or stretch the interval already being counted.
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            period_d = MAX_PERIOD - {1'b0, speed_in};
        end

        if ((state_d == ST_COMPUTE) && (state_q != ST_COMPUTE)) begin
            start_d = 1'b1;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        start_out     = start_q;
        swap_out      = swap_q;
        we_out        = (state_q == ST_CLEAR);
        addr_w_out    = (state_q == ST_CLEAR) ? clr_addr_q : '0;
        data_out      = '0;
        busy_out      = (state_q != ST_IDLE);
        gen_count_out = gen_count_q;
`ifdef LIFE_SEQ_TIMEOUT_EN
        err_out       = err_q;
`else
        err_out       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_life_sequencer.sv
// ---------------------------------------------------------------------------
// tb_life_sequencer
//
// Directed testbench for life_sequencer. Inputs change on the falling clock
// edge and outputs are sampled there too. A background monitor, sampling
// mid-cycle, counts start/swap pulses and records every clear write so that
// multi-cycle sequences can be checked after the fact.
// ---------------------------------------------------------------------------
module tb_life_sequencer;

    localparam int ADDR_SIZE     = 3;
    localparam int LINE_WIDTH    = 8;
    localparam int LOG_MAX_SPEED = 3;
    localparam int GEN_WIDTH     = 16;
    localparam int DEPTH         = 2 ** ADDR_SIZE;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic [LOG_MAX_SPEED-1:0] speed_in;
    logic                     run_in;
    logic                     step_in;
    logic                     clear_in;
    logic                     vsync_in;
    logic                     logic_done_in;
    logic                     start_out;
    logic                     swap_out;
    logic                     we_out;
    logic [ADDR_SIZE-1:0]     addr_w_out;
    logic [LINE_WIDTH-1:0]    data_out;
    logic                     busy_out;
    logic [GEN_WIDTH-1:0]     gen_count_out;
    logic                     err_out;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int swap_cnt = 0;
    int overlap_cnt = 0;
    int we_addr[$];
    int we_data[$];

    life_sequencer #(
        .ADDR_SIZE     (ADDR_SIZE),
        .LINE_WIDTH    (LINE_WIDTH),
        .LOG_MAX_SPEED (LOG_MAX_SPEED),
        .GEN_WIDTH     (GEN_WIDTH)
`ifdef LIFE_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .speed_in      (speed_in),
        .run_in        (run_in),
        .step_in       (step_in),
        .clear_in      (clear_in),
        .vsync_in      (vsync_in),
        .logic_done_in (logic_done_in),
        .start_out     (start_out),
        .swap_out      (swap_out),
        .we_out        (we_out),
        .addr_w_out    (addr_w_out),
        .data_out      (data_out),
        .busy_out      (busy_out),
        .gen_count_out (gen_count_out),
        .err_out       (err_out)
    );

    // 10 ns clock.
    always #5 clk_in = ~clk_in;

    // Mid-cycle monitor: counts output pulses and logs clear writes.
    always begin
        @(posedge clk_in);
        #4;
        if (start_out) start_cnt++;
        if (swap_out) swap_cnt++;
        if (start_out && swap_out) overlap_cnt++;
        if (we_out) begin
            we_addr.push_back(int'(addr_w_out));
            we_data.push_back(int'(data_out));
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of controls; pulses drop afterwards, run_in is held.
    task automatic applyStimulus(input logic run, input logic step,
                                 input logic clear, input logic done);
        run_in        = run;
        step_in       = step;
        clear_in      = clear;
        logic_done_in = done;
        @(negedge clk_in);
        step_in       = 1'b0;
        clear_in      = 1'b0;
        logic_done_in = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    // One vsync rising edge, then vsync low long enough for the next edge.
    task automatic frameTick();
        vsync_in = 1'b1;
        @(negedge clk_in);
        vsync_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic applyReset();
        rst_in        = 1'b1;
        run_in        = 1'b0;
        step_in       = 1'b0;
        clear_in      = 1'b0;
        logic_done_in = 1'b0;
        vsync_in      = 1'b0;
        waitCycles(2);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        int s0;
        int w0;
        rst_in        = 1'b1;
        speed_in      = '0;
        run_in        = 1'b0;
        step_in       = 1'b0;
        clear_in      = 1'b0;
        vsync_in      = 1'b0;
        logic_done_in = 1'b0;
        waitCycles(2);

        $display("[TB] reset values");
        checkOutput("rst_start", int'(start_out), 0);
        checkOutput("rst_swap", int'(swap_out), 0);
        checkOutput("rst_we", int'(we_out), 0);
        checkOutput("rst_addr", int'(addr_w_out), 0);
        checkOutput("rst_data", int'(data_out), 0);
        checkOutput("rst_busy", int'(busy_out), 0);
        checkOutput("rst_gen", int'(gen_count_out), 0);
        checkOutput("rst_err", int'(err_out), 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] done outside compute is ignored");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_done_busy", int'(busy_out), 0);

        $display("[TB] single step");
        s0 = start_cnt;
        w0 = swap_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("step_start", int'(start_out), 1);
        checkOutput("step_busy", int'(busy_out), 1);
        @(negedge clk_in);
        checkOutput("step_start_len", int'(start_out), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("step_swap_held", swap_cnt - w0, 0);
        checkOutput("step_busy_swap", int'(busy_out), 1);
        frameTick();
        checkOutput("step_swap", swap_cnt - w0, 1);
        checkOutput("step_starts", start_cnt - s0, 1);
        checkOutput("step_gen", int'(gen_count_out), 1);
        checkOutput("step_idle", int'(busy_out), 0);

        $display("[TB] free run, speed 5 (every 3rd frame)");
        applyReset();
        speed_in = 3'd5;
        w0 = swap_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            s0 = start_cnt;
            frameTick();
            frameTick();
            checkOutput("run_no_early_start", start_cnt - s0, 0);
            frameTick();
            checkOutput("run_start", start_cnt - s0, 1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            frameTick();
            checkOutput("run_swaps", swap_cnt - w0, g + 1);
        end
        checkOutput("run_gen", int'(gen_count_out), 4);
        checkOutput("run_busy", int'(busy_out), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pause_idle", int'(busy_out), 0);

        $display("[TB] speed extremes and speed sampling");
        applyReset();
        speed_in = 3'd7;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        s0 = start_cnt;
        frameTick();
        checkOutput("fast_start", start_cnt - s0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        frameTick();
        speed_in = 3'd0;
        s0 = start_cnt;
        frameTick();
        checkOutput("speed_sampled", start_cnt - s0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        frameTick();
        s0 = start_cnt;
        for (int i = 0; i < 7; i++) frameTick();
        checkOutput("slow_no_start", start_cnt - s0, 0);
        frameTick();
        checkOutput("slow_start", start_cnt - s0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        frameTick();
        checkOutput("run_drop_gen", int'(gen_count_out), 3);
        checkOutput("run_drop_idle", int'(busy_out), 0);

        $display("[TB] clear during compute");
        applyReset();
        w0 = swap_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clrc_we_early", int'(we_out), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        we_addr.delete();
        we_data.delete();
        frameTick();
        checkOutput("clrc_swap1", swap_cnt - w0, 1);
        checkOutput("clrc_gen1", int'(gen_count_out), 1);
        waitCycles(8);
        checkOutput("clrc_writes", we_addr.size(), DEPTH);
        for (int i = 0; i < we_addr.size(); i++) begin
            checkOutput("clrc_addr", we_addr[i], i);
            checkOutput("clrc_data", we_data[i], 0);
        end
        checkOutput("clrc_we_done", int'(we_out), 0);
        checkOutput("clrc_wait_busy", int'(busy_out), 1);
        checkOutput("clrc_no_swap_yet", swap_cnt - w0, 1);
        frameTick();
        checkOutput("clrc_swap2", swap_cnt - w0, 2);
        checkOutput("clrc_gen0", int'(gen_count_out), 0);
        checkOutput("clrc_idle", int'(busy_out), 0);

        $display("[TB] clear and step together");
        applyReset();
        we_addr.delete();
        we_data.delete();
        s0 = start_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_start", int'(start_out), 0);
        checkOutput("both_we", int'(we_out), 1);
        checkOutput("both_addr0", int'(addr_w_out), 0);
        waitCycles(10);
        checkOutput("both_no_start", start_cnt - s0, 0);
        checkOutput("both_writes", we_addr.size(), DEPTH);
        frameTick();
        checkOutput("both_idle", int'(busy_out), 0);

        $display("[TB] reset in the middle of a clear");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("midclr_addr", int'(addr_w_out), 3);
        rst_in = 1'b1;
        #1;
        checkOutput("midclr_we", int'(we_out), 0);
        checkOutput("midclr_addr_rst", int'(addr_w_out), 0);
        checkOutput("midclr_busy", int'(busy_out), 0);
        checkOutput("midclr_gen", int'(gen_count_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        waitCycles(2);
        checkOutput("midclr_abandoned", int'(busy_out), 0);

`ifdef LIFE_SEQ_TIMEOUT_EN
        $display("[TB] compute watchdog");
        applyReset();
        w0 = swap_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("to_start", int'(start_out), 1);
        waitCycles(15);
        checkOutput("to_err_before", int'(err_out), 0);
        checkOutput("to_busy_before", int'(busy_out), 1);
        @(negedge clk_in);
        checkOutput("to_err", int'(err_out), 1);
        checkOutput("to_idle", int'(busy_out), 0);
        checkOutput("to_no_swap", swap_cnt - w0, 0);
        checkOutput("to_gen", int'(gen_count_out), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("to_err_sticky", int'(err_out), 1);
        waitCycles(9);
        frameTick();
        checkOutput("to_err_cleared", int'(err_out), 0);
`else
        $display("[TB] compute waits without a watchdog");
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitCycles(40);
        checkOutput("nowd_busy", int'(busy_out), 1);
        checkOutput("nowd_err", int'(err_out), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        frameTick();
        checkOutput("nowd_gen", int'(gen_count_out), 1);
`endif

        checkOutput("start_swap_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
